// File: rtl/usb_transmitter.sv
// Full-speed USB transmitter: SYNC, NRZI-encoded bit-stuffed packet bytes read
// from the shared packet buffer, then EOP. One bit time is 4 clock48 cycles.
module usb_transmitter #(
  parameter int USB_PACKET_BUFFER_SIZE = 1024,
  localparam int AW  = $clog2(USB_PACKET_BUFFER_SIZE / 4),
  localparam int BCW = $clog2(USB_PACKET_BUFFER_SIZE) + 1
) (
  input  logic           clock48,
  input  logic           reset,
  input  logic           start,
  input  logic [BCW-1:0] byte_count,
  output logic [AW-1:0]  packet_buffer_address,
  input  logic [31:0]    packet_buffer_read_value,
  output logic           usb_d_p_out,
  output logic           usb_d_n_out,
  output logic           usb_oe,
  output logic           busy,
  output logic           done
);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP_SE0, S_EOP_J} state_t;

  state_t         state_reg, state_next;
  logic [1:0]     phase_reg, phase_next;
  logic [2:0]     bit_idx_reg, bit_idx_next;
  logic [BCW-1:0] byte_idx_reg, byte_idx_next;
  logic [BCW-1:0] byte_count_reg, byte_count_next;
  logic [2:0]     stuff_cnt_reg, stuff_cnt_next;
  logic [31:0]    word_reg, word_next;
  logic [AW-1:0]  address_reg, address_next;
  logic           d_p_reg, d_p_next;
  logic           d_n_reg, d_n_next;
  logic           oe_reg, oe_next;
  logic           busy_reg, busy_next;
  logic           done_reg, done_next;

  logic           bit_tick;
  logic           stuff_due;
  logic           last_byte;
  logic [2:0]     next_bit_idx;
  logic [BCW-1:0] next_byte;
  logic           send_bit;
  logic           tx_bit;

  assign bit_tick     = (phase_reg == 2'd3);
  assign stuff_due    = (stuff_cnt_reg == 3'd6);
  assign next_bit_idx = bit_idx_reg + 3'd1;
  assign next_byte    = byte_idx_reg + BCW'(1);
  assign last_byte    = (next_byte == byte_count_reg);

  always_ff @(posedge clock48 or posedge reset) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      phase_reg      <= '0;
      bit_idx_reg    <= '0;
      byte_idx_reg   <= '0;
      byte_count_reg <= '0;
      stuff_cnt_reg  <= '0;
      word_reg       <= '0;
      address_reg    <= '0;
      d_p_reg        <= 1'b1;
      d_n_reg        <= 1'b0;
      oe_reg         <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      phase_reg      <= phase_next;
      bit_idx_reg    <= bit_idx_next;
      byte_idx_reg   <= byte_idx_next;
      byte_count_reg <= byte_count_next;
      stuff_cnt_reg  <= stuff_cnt_next;
      word_reg       <= word_next;
      address_reg    <= address_next;
      d_p_reg        <= d_p_next;
      d_n_reg        <= d_n_next;
      oe_reg         <= oe_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (start) state_next = S_SYNC;
      S_SYNC:    if (bit_tick && bit_idx_reg == 3'd7)
                   state_next = (byte_count_reg == '0) ? S_EOP_SE0 : S_DATA;
      S_DATA:    if (bit_tick && !stuff_due && bit_idx_reg == 3'd7 && last_byte)
                   state_next = S_EOP_SE0;
      S_EOP_SE0: if (bit_tick && bit_idx_reg == 3'd1) state_next = S_EOP_J;
      S_EOP_J:   if (bit_tick) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Every decision is taken in the last cycle of a bit so the new line level
  // lands in the output registers exactly on the bit boundary.
  always_comb begin
    phase_next      = oe_reg ? phase_reg + 2'd1 : 2'd0;
    bit_idx_next    = bit_idx_reg;
    byte_idx_next   = byte_idx_reg;
    byte_count_next = byte_count_reg;
    stuff_cnt_next  = stuff_cnt_reg;
    word_next       = word_reg;
    address_next    = address_reg;
    d_p_next        = d_p_reg;
    d_n_next        = d_n_reg;
    oe_next         = oe_reg;
    busy_next       = busy_reg;
    done_next       = 1'b0;
    send_bit        = 1'b0;
    tx_bit          = 1'b0;
    case (state_reg)
      S_IDLE: if (start) begin
        byte_count_next = byte_count;
        address_next    = '0;
        bit_idx_next    = '0;
        byte_idx_next   = '0;
        oe_next         = 1'b1;
        busy_next       = 1'b1;
        phase_next      = 2'd0;
        send_bit        = 1'b1;
      end
      S_SYNC: if (bit_tick) begin
        bit_idx_next = '0;
        if (bit_idx_reg != 3'd7) begin
          bit_idx_next = next_bit_idx;
          send_bit     = 1'b1;
          tx_bit       = (next_bit_idx == 3'd7);
        end else if (byte_count_reg == '0) begin
          d_p_next = 1'b0;
          d_n_next = 1'b0;
        end else begin
          word_next = packet_buffer_read_value;
          send_bit  = 1'b1;
          tx_bit    = packet_buffer_read_value[0];
        end
      end
      S_DATA: if (bit_tick) begin
        if (stuff_due) begin
          send_bit = 1'b1;
        end else if (bit_idx_reg != 3'd7) begin
          bit_idx_next = next_bit_idx;
          send_bit     = 1'b1;
          tx_bit       = word_reg[{byte_idx_reg[1:0], next_bit_idx}];
        end else if (last_byte) begin
          bit_idx_next = '0;
          d_p_next     = 1'b0;
          d_n_next     = 1'b0;
        end else begin
          byte_idx_next = next_byte;
          bit_idx_next  = '0;
          send_bit      = 1'b1;
          if (next_byte[1:0] == 2'd0) begin
            word_next = packet_buffer_read_value;
            tx_bit    = packet_buffer_read_value[0];
          end else begin
            tx_bit = word_reg[{next_byte[1:0], 3'd0}];
          end
          // Prefetch the following word while this word's last byte is on the line.
          if (next_byte[1:0] == 2'd3 && (next_byte + BCW'(1)) < byte_count_reg)
            address_next = address_reg + AW'(1);
        end
      end
      S_EOP_SE0: if (bit_tick) begin
        if (bit_idx_reg == 3'd0) begin
          bit_idx_next = 3'd1;
        end else begin
          bit_idx_next = '0;
          d_p_next     = 1'b1;
          d_n_next     = 1'b0;
        end
      end
      S_EOP_J: if (bit_tick) begin
        oe_next    = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b1;
        phase_next = 2'd0;
      end
      default: ;
    endcase
    // NRZI: a 0 (data or stuff) flips J/K, a 1 holds the line.
    if (send_bit) begin
      d_p_next       = tx_bit ? d_p_reg : ~d_p_reg;
      d_n_next       = tx_bit ? d_n_reg : ~d_n_reg;
      stuff_cnt_next = tx_bit ? stuff_cnt_reg + 3'd1 : 3'd0;
    end
  end

  assign packet_buffer_address = address_reg;
  assign usb_d_p_out           = d_p_reg;
  assign usb_d_n_out           = d_n_reg;
  assign usb_oe                = oe_reg;
  assign busy                  = busy_reg;
  assign done                  = done_reg;

endmodule

// File: tb/tb_usb_transmitter.sv
// Randomized scoreboard bench for usb_transmitter: a bit-list reference model
// predicts each packet's line symbols; a monitor captures and compares them.
module tb_usb_transmitter;
  localparam int AW  = 8;
  localparam int BCW = 11;
  localparam logic [1:0] LJ = 2'b10, LK = 2'b01, LSE0 = 2'b00;

  logic           clock48 = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [BCW-1:0] byte_count = '0;
  logic [AW-1:0]  packet_buffer_address;
  logic [31:0]    packet_buffer_read_value = '0;
  logic           usb_d_p_out, usb_d_n_out, usb_oe, busy, done;

  usb_transmitter #(.USB_PACKET_BUFFER_SIZE(1024)) dut (
    .clock48(clock48), .reset(reset), .start(start), .byte_count(byte_count),
    .packet_buffer_address(packet_buffer_address),
    .packet_buffer_read_value(packet_buffer_read_value),
    .usb_d_p_out(usb_d_p_out), .usb_d_n_out(usb_d_n_out),
    .usb_oe(usb_oe), .busy(busy), .done(done)
  );

  always #10 clock48 = ~clock48;

  logic [31:0] mem [0:255];
  always @(posedge clock48) packet_buffer_read_value <= mem[packet_buffer_address];

  int cyc = 0;
  always @(posedge clock48) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int exp_t_q[$];
  int exp_len_q[$];
  int exp_addr_q[$];
  logic [1:0] exp_sym_q[$];

  function automatic void check(input bit ok, input string name, input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, msg);
    end
  endfunction

  task automatic finish_sim();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Reference: build the raw bit list, stuff it, NRZI it, append EOP.
  task automatic model_push(input int n);
    bit raw[$];
    bit stf[$];
    int ones;
    logic [1:0] lvl;
    logic [31:0] w;
    logic [7:0] bv;
    for (int i = 0; i < 8; i++) raw.push_back(i == 7);
    for (int k = 0; k < n; k++) begin
      w  = mem[k / 4];
      bv = 8'(w >> (8 * (k % 4)));
      for (int j = 0; j < 8; j++) raw.push_back(bv[j]);
    end
    ones = 0;
    foreach (raw[i]) begin
      stf.push_back(raw[i]);
      ones = raw[i] ? ones + 1 : 0;
      if (ones == 6) begin
        stf.push_back(1'b0);
        ones = 0;
      end
    end
    lvl = LJ;
    foreach (stf[i]) begin
      if (!stf[i]) lvl = (lvl == LJ) ? LK : LJ;
      exp_sym_q.push_back(lvl);
    end
    exp_sym_q.push_back(LSE0);
    exp_sym_q.push_back(LSE0);
    exp_sym_q.push_back(LJ);
    exp_len_q.push_back(stf.size() + 3);
    exp_addr_q.push_back((n <= 4) ? 0 : (n - 1) / 4);
  endtask

  // Monitor
  bit prev_oe = 1'b0;
  int m_cnt = 0;
  int m_max_addr = 0;
  int tx_num = 0;
  bit m_stable, m_busy_ok;
  logic [1:0] got_q[$];
  logic [1:0] cur;

  function automatic void finish_tx();
    int len, ea, bad;
    logic [1:0] e;
    if (exp_len_q.size() == 0) begin
      check(1'b0, "unexpected_end", $sformatf("oe fell at cycle %0d, required no transmission", cyc));
      return;
    end
    len = exp_len_q.pop_front();
    tx_num++;
    if (len < 0) begin
      check(!done && !busy, "abort_quiet",
            $sformatf("done=%0b busy=%0b, required done=0 busy=0", done, busy));
      $display("tx %0d: aborted by reset after %0d cycles", tx_num, m_cnt);
      return;
    end
    check(done && !busy, "done_pulse", $sformatf("done=%0b busy=%0b, required 1/0", done, busy));
    check(cur == LJ, "idle_J", $sformatf("line=%b, required %b", cur, LJ));
    check(m_cnt == len * 4, "duration", $sformatf("%0d cycles, required %0d", m_cnt, len * 4));
    bad = -1;
    for (int i = 0; i < len; i++) begin
      e = exp_sym_q.pop_front();
      if (bad < 0 && (i >= got_q.size() || got_q[i] != e)) bad = i;
    end
    check(bad < 0 && got_q.size() == len, "line_seq",
          $sformatf("first bad bit %0d, got %0d bits, required %0d", bad, got_q.size(), len));
    check(m_stable, "bit_stable", "line changed inside a bit time, required steady");
    check(m_busy_ok, "busy_high", "busy low while usb_oe high, required 1");
    ea = exp_addr_q.pop_front();
    check(m_max_addr == ea, "addr_max", $sformatf("%0d, required %0d", m_max_addr, ea));
    $display("tx %0d: %0d bit times, %0d cycles, last word address %0d", tx_num, len, m_cnt, m_max_addr);
  endfunction

  always @(negedge clock48) begin
    cur = {usb_d_p_out, usb_d_n_out};
    if (usb_oe && !prev_oe) begin
      if (exp_t_q.size() == 0)
        check(1'b0, "unexpected_tx", $sformatf("oe rose at cycle %0d, required idle", cyc));
      else begin
        int et;
        et = exp_t_q.pop_front();
        check(cyc == et, "start_latency", $sformatf("oe rose at cycle %0d, required %0d", cyc, et));
      end
      check(packet_buffer_address == '0, "addr_start",
            $sformatf("%0d, required 0", packet_buffer_address));
      m_cnt = 0;
      got_q.delete();
      m_stable = 1'b1;
      m_busy_ok = 1'b1;
      m_max_addr = 0;
    end
    if (usb_oe) begin
      if (m_cnt % 4 == 0) got_q.push_back(cur);
      else if (cur != got_q[$]) m_stable = 1'b0;
      if (!busy) m_busy_ok = 1'b0;
      if (int'(packet_buffer_address) > m_max_addr) m_max_addr = int'(packet_buffer_address);
      m_cnt++;
    end
    if (prev_oe && !usb_oe) finish_tx();
    else if (done) check(1'b0, "done_spurious", $sformatf("done=1 at cycle %0d, required 0", cyc));
    prev_oe = usb_oe;
  end

  // Stimulus
  task automatic wait_signal(input bit want_done);
    int k;
    k = 0;
    while ((want_done ? !done : busy) && k < 5000) begin
      @(negedge clock48);
      k++;
    end
    if (want_done ? !done : busy) begin
      check(1'b0, "timeout", $sformatf("waited %0d cycles for %s", k, want_done ? "done" : "idle"));
      finish_sim();
    end
  endtask

  task automatic send(input int n, input logic [31:0] w0, input logic [31:0] w1,
                      input logic [31:0] w2, input logic [31:0] w3, input bit mid, input bit b2b);
    if (b2b && busy) wait_signal(1'b1);
    else begin
      wait_signal(1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clock48);
    end
    mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
    model_push(n);
    exp_t_q.push_back(cyc + 1);
    start = 1'b1;
    byte_count = BCW'(n);
    @(negedge clock48);
    start = 1'b0;
    byte_count = BCW'($urandom);
    if (mid && n >= 2) begin
      repeat (40) @(negedge clock48);
      start = 1'b1;
      byte_count = BCW'($urandom_range(0, 12));
      @(negedge clock48);
      start = 1'b0;
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = ($urandom % 3 == 0) ? 8'hFF : 8'($urandom);
    return w;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge clock48);
    check(!usb_oe && !busy && !done, "reset_ctrl",
          $sformatf("oe=%0b busy=%0b done=%0b, required 0/0/0", usb_oe, busy, done));
    check(usb_d_p_out && !usb_d_n_out, "reset_line",
          $sformatf("dp=%0b dn=%0b, required J", usb_d_p_out, usb_d_n_out));
    check(packet_buffer_address == '0, "reset_addr", $sformatf("%0d, required 0", packet_buffer_address));
    reset = 1'b0;
    repeat (2) @(negedge clock48);
    check(!usb_oe && !busy, "idle_after_reset", $sformatf("oe=%0b busy=%0b, required 0/0", usb_oe, busy));

    send(1, 32'h0000_00D2, 0, 0, 0, 1'b0, 1'b0);
    send(2, 32'h0000_FFFF, 0, 0, 0, 1'b0, 1'b0);
    send(6, 32'h4433_2211, 32'h0000_6655, 0, 0, 1'b0, 1'b0);
    send(1, 32'h0000_00FC, 0, 0, 0, 1'b0, 1'b0);
    send(0, 32'hFFFF_FFFF, 0, 0, 0, 1'b0, 1'b0);
    send(3, 32'h00FF_7E81, 0, 0, 0, 1'b1, 1'b0);
    send(5, 32'hFFFF_FFFF, 32'h0000_00FF, 0, 0, 1'b0, 1'b1);

    // Reset in the middle of SYNC bit 3; no done may follow.
    wait_signal(1'b0);
    mem[0] = 32'h0000_00A5;
    exp_t_q.push_back(cyc + 1);
    exp_len_q.push_back(-1);
    start = 1'b1;
    byte_count = BCW'(2);
    @(negedge clock48);
    start = 1'b0;
    repeat (13) @(negedge clock48);
    #1 reset = 1'b1;
    #1;
    check(!usb_oe && !busy, "reset_async",
          $sformatf("oe=%0b busy=%0b right after reset, required 0/0", usb_oe, busy));
    check(usb_d_p_out && !usb_d_n_out, "reset_async_line",
          $sformatf("dp=%0b dn=%0b, required J", usb_d_p_out, usb_d_n_out));
    repeat (3) @(negedge clock48);
    reset = 1'b0;
    @(negedge clock48);
    send(2, 32'h0000_C3D2, 0, 0, 0, 1'b0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      int n;
      n = $urandom_range(0, 12);
      send(n, rand_word(), rand_word(), rand_word(), rand_word(),
           ($urandom % 4) == 0, ($urandom % 3) == 0);
    end

    wait_signal(1'b0);
    repeat (5) @(negedge clock48);
    check(exp_len_q.size() == 0 && exp_t_q.size() == 0, "drain",
          $sformatf("%0d ends, %0d starts outstanding, required 0", exp_len_q.size(), exp_t_q.size()));
    finish_sim();
  end

  initial begin
    #3000000;
    check(1'b0, "watchdog", "simulation time limit reached, required completion");
    finish_sim();
  end
endmodule
